matmul_arbiter: RTL and testbench

- Shares one sequential_matrix_multiplier between two client requesters with round-robin arbitration.
- Sequences each job: drives mul_start, steers the multiplier's operand fetch indices to the granted client's A/B storage, and buffers result elements into a one-entry holding register.
- Routes each buffered result to the granted client over a valid/ready handshake and pulses a per-client job-done.
- Sits between the multiplier core and client-side operand and result memories.

---
 rtl/matmul_pkg.sv | 20 ++
 rtl/matmul_rr_arb2.sv | 48 ++++
 rtl/matmul_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_matmul_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and constants for the two-client matrix-multiplier arbiter.
package matmul_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    localparam int N_DEF  = 4;
    localparam int IW_DEF = 2;
    localparam int DW_DEF = 32;

    // Number of result elements produced by one N x N job.
    function automatic int nn_count(input int n);
        return n * n;
    endfunction

endpackage

// File: rtl/matmul_rr_arb2.sv
// Two-way round-robin pick with a pointer register naming the preferred client.
module matmul_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_winner
);

    logic r_ptr;
    logic [1:0] w_winner;

    // Pointer client wins if it requests, otherwise the other requester.
    always_comb begin
        w_winner = 2'b00;
        if (r_ptr == 1'b0) begin
            if (i_req[0]) begin
                w_winner = 2'b01;
            end else if (i_req[1]) begin
                w_winner = 2'b10;
            end else begin
                w_winner = 2'b00;
            end
        end else begin
            if (i_req[1]) begin
                w_winner = 2'b10;
            end else if (i_req[0]) begin
                w_winner = 2'b01;
            end else begin
                w_winner = 2'b00;
            end
        end
    end

    // After each grant the pointer moves to the client that lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 1'b0;
        end else if (i_update) begin
            r_ptr <= (w_winner == 2'b01) ? 1'b1 : 1'b0;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_winner = w_winner;

endmodule

// File: rtl/matmul_arbiter.sv
// Shares one sequential matrix multiplier between two clients; buffers one result.
// Optional watchdog abort enabled by defining MATMUL_ARB_TIMEOUT_EN.
module matmul_arbiter
    import matmul_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int IW      = IW_DEF,
    parameter int DW      = DW_DEF,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req,
    output logic [1:0]    gnt,
    output logic [1:0]    job_done,
    output logic          mul_start,
    input  logic          mul_done,
    input  logic [IW-1:0] mul_a_i,
    input  logic [IW-1:0] mul_a_j,
    input  logic [IW-1:0] mul_b_i,
    input  logic [IW-1:0] mul_b_j,
    output logic [DW-1:0] mul_a_in,
    output logic [DW-1:0] mul_b_in,
    output logic [IW-1:0] rd_a_i,
    output logic [IW-1:0] rd_a_j,
    output logic [IW-1:0] rd_b_i,
    output logic [IW-1:0] rd_b_j,
    input  logic [DW-1:0] c0_a_data,
    input  logic [DW-1:0] c0_b_data,
    input  logic [DW-1:0] c1_a_data,
    input  logic [DW-1:0] c1_b_data,
    input  logic [DW-1:0] mul_z_out,
    input  logic [IW-1:0] mul_z_i,
    input  logic [IW-1:0] mul_z_j,
    input  logic          mul_z_stb,
    output logic          mul_z_ack,
    output logic [1:0]    res_valid,
    input  logic [1:0]    res_ready,
    output logic [IW-1:0] res_i,
    output logic [IW-1:0] res_j,
    output logic [DW-1:0] res_data
`ifdef MATMUL_ARB_TIMEOUT_EN
    ,
    output logic          timeout_err
`endif
);

    localparam int CW = $clog2(N * N + 1);
    localparam logic [CW-1:0] NN = CW'(nn_count(N));

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_gnt;
    logic [1:0]    r_job_done;
    logic          r_z_ack;
    logic          r_full;
    logic [DW-1:0] r_z_data;
    logic [IW-1:0] r_z_i;
    logic [IW-1:0] r_z_j;
    logic [CW-1:0] r_count;
    logic [1:0]    w_winner;
    logic          w_grant_take;
    logic          w_capture;
    logic          w_finish;
    logic          w_drain;
    logic          w_timeout;

    matmul_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (req),
        .i_update (w_grant_take),
        .o_winner (w_winner)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and per-cycle job control strobes.
    always_comb begin
        w_next       = r_state;
        w_grant_take = 1'b0;
        w_capture    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    w_next       = S_RUN;
                    w_grant_take = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_RUN: begin
                // Ack is a one-cycle pulse, so a strobe seen during the ack is the old element.
                w_capture = mul_z_stb & ~r_full & ~r_z_ack & ~w_timeout;
                if (w_timeout) begin
                    w_next = S_WAIT;
                end else if (mul_done && (r_count == NN) && !r_full) begin
                    w_next   = S_FINISH;
                    w_finish = 1'b1;
                end else begin
                    w_next = S_RUN;
                end
            end
            S_FINISH: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (!mul_done) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_drain = r_full & (|(r_gnt & res_ready));

    // Grant, job-done pulse, result holding register and result count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt      <= 2'b00;
            r_job_done <= 2'b00;
            r_z_ack    <= 1'b0;
            r_full     <= 1'b0;
            r_z_data   <= {DW{1'b0}};
            r_z_i      <= {IW{1'b0}};
            r_z_j      <= {IW{1'b0}};
            r_count    <= {CW{1'b0}};
        end else begin
            r_z_ack    <= w_capture;
            r_job_done <= w_finish ? r_gnt : 2'b00;
            if (w_grant_take) begin
                r_gnt <= w_winner;
            end else if ((r_state == S_FINISH) || w_timeout) begin
                r_gnt <= 2'b00;
            end else begin
                r_gnt <= r_gnt;
            end
            if (w_capture) begin
                r_full   <= 1'b1;
                r_z_data <= mul_z_out;
                r_z_i    <= mul_z_i;
                r_z_j    <= mul_z_j;
            end else if (w_drain || w_timeout) begin
                r_full <= 1'b0;
            end else begin
                r_full <= r_full;
            end
            if ((r_state == S_FINISH) || w_timeout) begin
                r_count <= {CW{1'b0}};
            end else if (w_capture) begin
                r_count <= r_count + CW'(1);
            end else begin
                r_count <= r_count;
            end
        end
    end

`ifdef MATMUL_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] r_wd;
    logic          r_timeout_err;

    assign w_timeout = (r_state == S_RUN) && (r_wd == WW'(TIMEOUT - 1));

    // Watchdog counts RUN cycles since the job started or the last ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd          <= {WW{1'b0}};
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (w_grant_take || r_z_ack || (r_state != S_RUN)) begin
                r_wd <= {WW{1'b0}};
            end else begin
                r_wd <= r_wd + WW'(1);
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout = 1'b0 && (TIMEOUT > 0);
`endif

    // Operand data comes from the granted client only.
    always_comb begin
        case (r_gnt)
            2'b01: begin
                mul_a_in = c0_a_data;
                mul_b_in = c0_b_data;
            end
            2'b10: begin
                mul_a_in = c1_a_data;
                mul_b_in = c1_b_data;
            end
            default: begin
                mul_a_in = {DW{1'b0}};
                mul_b_in = {DW{1'b0}};
            end
        endcase
    end

    assign rd_a_i    = mul_a_i;
    assign rd_a_j    = mul_a_j;
    assign rd_b_i    = mul_b_i;
    assign rd_b_j    = mul_b_j;
    assign gnt       = r_gnt;
    assign job_done  = r_job_done;
    assign mul_start = (r_state == S_RUN);
    assign mul_z_ack = r_z_ack;
    assign res_valid = r_full ? r_gnt : 2'b00;
    assign res_i     = r_z_i;
    assign res_j     = r_z_j;
    assign res_data  = r_z_data;

endmodule

// File: tb/tb_matmul_arbiter.sv
// Scoreboard bench for matmul_arbiter: a multiplier model issues results, a monitor checks them.
module tb_matmul_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int DW = 32;
    localparam logic [DW-1:0] C0A = 32'hA0A0_0001;
    localparam logic [DW-1:0] C0B = 32'hB0B0_0002;
    localparam logic [DW-1:0] C1A = 32'hA1A1_0003;
    localparam logic [DW-1:0] C1B = 32'hB1B1_0004;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] req, gnt, job_done, res_valid, res_ready;
    logic mul_start, mul_done, mul_z_stb, mul_z_ack;
    logic [IW-1:0] mul_a_i, mul_a_j, mul_b_i, mul_b_j;
    logic [IW-1:0] rd_a_i, rd_a_j, rd_b_i, rd_b_j;
    logic [IW-1:0] mul_z_i, mul_z_j, res_i, res_j;
    logic [DW-1:0] mul_a_in, mul_b_in, mul_z_out, res_data;
    logic [DW-1:0] c0_a_data, c0_b_data, c1_a_data, c1_b_data;
`ifdef MATMUL_ARB_TIMEOUT_EN
    logic timeout_err;
`endif

    typedef struct packed {
        logic [1:0]    cl;
        logic [IW-1:0] i;
        logic [IW-1:0] j;
        logic [DW-1:0] d;
    } res_t;

    res_t       exp_q[$];
    logic [1:0] exp_gnt[$];
    logic [1:0] exp_done[$];

    int n_tests = 0;
    int n_fail  = 0;
    int hs_job = 0, done_cnt = 0, to_seen = 0, since_ack = 0;
    int m_stall_at = 99, m_done_after = 16, m_done_hold = 3, m_job = 0;

    assign c0_a_data = C0A;
    assign c0_b_data = C0B;
    assign c1_a_data = C1A;
    assign c1_b_data = C1B;

    always #5 clk = ~clk;

    matmul_arbiter #(.N(N), .IW(IW), .DW(DW), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .job_done(job_done),
        .mul_start(mul_start), .mul_done(mul_done),
        .mul_a_i(mul_a_i), .mul_a_j(mul_a_j), .mul_b_i(mul_b_i), .mul_b_j(mul_b_j),
        .mul_a_in(mul_a_in), .mul_b_in(mul_b_in),
        .rd_a_i(rd_a_i), .rd_a_j(rd_a_j), .rd_b_i(rd_b_i), .rd_b_j(rd_b_j),
        .c0_a_data(c0_a_data), .c0_b_data(c0_b_data),
        .c1_a_data(c1_a_data), .c1_b_data(c1_b_data),
        .mul_z_out(mul_z_out), .mul_z_i(mul_z_i), .mul_z_j(mul_z_j),
        .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_i(res_i), .res_j(res_j), .res_data(res_data)
`ifdef MATMUL_ARB_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int t;
        t = 0;
        while (done_cnt < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(done_cnt >= target, name, done_cnt, target);
    endtask

    task automatic wait_hs(input int target, input string name);
        int t;
        t = 0;
        while (hs_job < target && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check(hs_job >= target, name, hs_job, target);
    endtask

    task automatic wait_gnt(input logic [1:0] g, input string name);
        int t;
        t = 0;
        while (gnt != g && t < 200) begin
            @(negedge clk);
            t++;
        end
        check(gnt == g, name, gnt, g);
    endtask

    // Multiplier model: strobes 16 results per job, waits for each ack, then raises done.
    logic [1:0] m_cl;
    bit m_aborted, m_got;
    initial begin : model
        mul_z_stb = 1'b0; mul_done = 1'b0; mul_z_out = '0; mul_z_i = '0; mul_z_j = '0;
        mul_a_i = '0; mul_a_j = '0; mul_b_i = '0; mul_b_j = '0;
        forever begin
            @(negedge clk);
            if (rst && mul_start) begin
                m_aborted = 1'b0;
                m_cl = gnt;
                for (int k = 0; k < 16 && !m_aborted; k++) begin
                    if (k == m_stall_at) begin
                        m_got = 1'b0;
                        for (int t = 0; t < 300 && !m_got; t++) begin
                            @(negedge clk);
                            m_got = !mul_start;
                        end
                        check(m_got, "stall_start_drop", mul_start, 0);
                        m_aborted = 1'b1;
                    end else begin
                        mul_z_i   = IW'(k / 4);
                        mul_z_j   = IW'(k % 4);
                        mul_z_out = 32'hD000_0000 | (32'(m_job) << 16) | 32'(k);
                        mul_a_i = mul_z_i; mul_a_j = mul_z_j; mul_b_i = mul_z_j; mul_b_j = mul_z_i;
                        mul_z_stb = 1'b1;
                        exp_q.push_back({m_cl, mul_z_i, mul_z_j, mul_z_out});
                        m_got = 1'b0;
                        for (int t = 0; t < 500 && !m_got && !m_aborted; t++) begin
                            @(negedge clk);
                            if (mul_z_ack) m_got = 1'b1;
                            else if (!mul_start) m_aborted = 1'b1;
                        end
                        if (!m_got && !m_aborted) begin
                            check(1'b0, "model_ack_timeout", 0, 1);
                            m_aborted = 1'b1;
                        end
                        mul_z_stb = 1'b0;
                        if (k + 1 == m_done_after) mul_done = 1'b1;
                    end
                end
                mul_z_stb = 1'b0;
                if (!m_aborted) begin
                    mul_done = 1'b1;
                    m_got = 1'b0;
                    for (int t = 0; t < 200 && !m_got; t++) begin
                        @(negedge clk);
                        m_got = !mul_start;
                    end
                    check(m_got, "finish_reached", mul_start, 0);
                    repeat (m_done_hold) @(negedge clk);
                end
                mul_done = 1'b0;
                m_job++;
            end
        end
    end

    // Monitor: grant order, operand steering, result handshakes and job-done pulses.
    logic [1:0] prev_gnt = 2'b00;
    initial begin : monitor
        res_t e, g;
        logic [1:0] eg;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hs_job = 0;
                exp_q.delete();
                prev_gnt = 2'b00;
            end else begin
                if (gnt != prev_gnt) begin
                    if (gnt != 2'b00) begin
                        if (exp_gnt.size() == 0) begin
                            check(1'b0, "unexpected_gnt", gnt, 0);
                        end else begin
                            eg = exp_gnt.pop_front();
                            check(gnt == eg, "gnt_order", gnt, eg);
                        end
                        check({mul_a_in, mul_b_in} == ((gnt == 2'b01) ? {C0A, C0B} : {C1A, C1B}),
                              "operand_mux", {mul_a_in, mul_b_in}, (gnt == 2'b01) ? {C0A, C0B} : {C1A, C1B});
                        check({rd_a_i, rd_a_j, rd_b_i, rd_b_j} == {mul_a_i, mul_a_j, mul_b_i, mul_b_j},
                              "rd_index_pass", {rd_a_i, rd_a_j, rd_b_i, rd_b_j}, {mul_a_i, mul_a_j, mul_b_i, mul_b_j});
                    end else begin
                        check({mul_a_in, mul_b_in} == 64'd0, "operand_no_gnt", {mul_a_in, mul_b_in}, 0);
                    end
                    prev_gnt = gnt;
                end
                if (res_valid != 2'b00) check(res_valid == gnt, "res_valid_route", res_valid, gnt);
                for (int c = 0; c < 2; c++) begin
                    if (res_valid[c] && res_ready[c]) begin
                        g = {((c == 0) ? 2'b01 : 2'b10), res_i, res_j, res_data};
                        if (exp_q.size() == 0) begin
                            check(1'b0, "unexpected_result", g, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check(g == e, "result", g, e);
                        end
                        hs_job++;
                    end
                end
                if (job_done != 2'b00) begin
                    if (exp_done.size() == 0) begin
                        check(1'b0, "unexpected_job_done", job_done, 0);
                    end else begin
                        eg = exp_done.pop_front();
                        check(job_done == eg, "job_done", job_done, eg);
                    end
                    check(hs_job == 16, "job_result_count", hs_job, 16);
                    hs_job = 0;
                    done_cnt++;
                end
                since_ack = mul_z_ack ? 0 : since_ack + 1;
`ifdef MATMUL_ARB_TIMEOUT_EN
                if (timeout_err) begin
                    check(since_ack >= 64 && since_ack <= 66, "timeout_latency", since_ack, 64);
                    check(!mul_start && gnt == 2'b00, "timeout_stop", {mul_start, gnt}, 0);
                    hs_job = 0;
                    to_seen++;
                end
`endif
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        bit okc;
        int acks;
        rst = 1'b0; req = 2'b00; res_ready = 2'b11;
        repeat (2) @(negedge clk);
        check({gnt, job_done, mul_start, mul_z_ack, res_valid} == 8'd0, "reset_state",
              {gnt, job_done, mul_start, mul_z_ack, res_valid}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Both clients requesting: strict alternation starting at client 0.
        exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b10); exp_gnt.push_back(2'b01); exp_gnt.push_back(2'b10);
        exp_done.push_back(2'b01); exp_done.push_back(2'b10); exp_done.push_back(2'b01); exp_done.push_back(2'b10);
        req = 2'b11;
        wait_done(4, "alternate_jobs");
        req = 2'b00;
        repeat (5) @(negedge clk);

        // Single client: grant one cycle after request, request dropped mid-job.
        exp_gnt.push_back(2'b01); exp_done.push_back(2'b01);
        req = 2'b01;
        @(posedge clk); #1;
        check(gnt == 2'b01, "gnt_latency", gnt, 2'b01);
        @(negedge clk);
        req = 2'b00;
        wait_done(5, "single_job");
        repeat (5) @(negedge clk);

        // Back-pressure on client 0 for 20 cycles.
        exp_gnt.push_back(2'b01); exp_done.push_back(2'b01);
        req = 2'b01;
        wait_gnt(2'b01, "bp_gnt");
        req = 2'b00;
        wait_hs(6, "bp_progress");
        res_ready = 2'b10;
        acks = 0;
        repeat (20) begin
            @(negedge clk);
            if (mul_z_ack) acks++;
        end
        check(acks <= 1, "stall_no_ack", acks, 1);
        check(res_valid == 2'b01, "stall_holds_valid", res_valid, 2'b01);
        res_ready = 2'b11;
        wait_done(6, "bp_job");
        repeat (5) @(negedge clk);

        // Early done after 10 results, then done held high keeps the FSM in WAIT.
        m_done_after = 10; m_done_hold = 12;
        exp_gnt.push_back(2'b01); exp_done.push_back(2'b01);
        exp_gnt.push_back(2'b01); exp_done.push_back(2'b01);
        req = 2'b01;
        wait_done(7, "early_done_job");
        m_done_after = 16; m_done_hold = 3;
        okc = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (gnt != 2'b00) okc = 1'b0;
        end
        check(okc, "wait_holds_on_done", gnt, 0);
        wait_gnt(2'b01, "after_wait_gnt");
        req = 2'b00;
        wait_done(8, "after_wait_job");
        repeat (5) @(negedge clk);

        // Reset in the middle of a job, then restart for client 1.
        exp_gnt.push_back(2'b01);
        req = 2'b01;
        wait_gnt(2'b01, "rst_job_gnt");
        req = 2'b00;
        wait_hs(5, "rst_job_progress");
        rst = 1'b0;
        #1;
        check({gnt, job_done, mul_start, mul_z_ack, res_valid} == 8'd0, "reset_mid_run",
              {gnt, job_done, mul_start, mul_z_ack, res_valid}, 0);
        repeat (3) @(negedge clk);
        req = 2'b10;
        exp_gnt.push_back(2'b10); exp_done.push_back(2'b10);
        rst = 1'b1;
        wait_gnt(2'b10, "restart_gnt");
        req = 2'b00;
        wait_done(9, "restart_job");
        repeat (5) @(negedge clk);

`ifdef MATMUL_ARB_TIMEOUT_EN
        // Model stalls after three results; watchdog aborts without job_done.
        m_stall_at = 3;
        exp_gnt.push_back(2'b01);
        req = 2'b01;
        wait_gnt(2'b01, "to_gnt");
        req = 2'b00;
        begin
            int t;
            t = 0;
            while (to_seen < 1 && t < 400) begin
                @(negedge clk);
                t++;
            end
        end
        check(to_seen == 1, "timeout_seen", to_seen, 1);
        m_stall_at = 99;
        repeat (5) @(negedge clk);
        check({gnt, mul_start} == 3'd0, "timeout_idle", {gnt, mul_start}, 0);
        exp_gnt.push_back(2'b01); exp_done.push_back(2'b01);
        req = 2'b01;
        wait_gnt(2'b01, "post_to_gnt");
        req = 2'b00;
        wait_done(10, "post_to_job");
        repeat (5) @(negedge clk);
`endif

        check(exp_q.size() == 0, "results_left", exp_q.size(), 0);
        check(exp_gnt.size() == 0, "grants_left", exp_gnt.size(), 0);
        check(exp_done.size() == 0, "dones_left", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
